food_controller: RTL

//  Sequences food placement for the snake game. Samples the free-running random

---
 rtl/food_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/food_controller.sv
// Food placement sequencer for the snake game: draws random candidates, rejects
// out-of-field or on-body positions by scanning body RAM, then tracks eating and score.
module food_controller #(
    parameter int          MAX_LEN    = 32,
    parameter int          ADDR_W     = 5,
    parameter int          MAX_TRIES  = 8,
    parameter int          X_MIN      = 10,
    parameter int          X_MAX      = 620,
    parameter int          Y_MIN      = 10,
    parameter int          Y_MAX      = 460,
    parameter logic [15:0] SCORE_INIT = 16'h0000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              move_tick,
    input  logic [9:0]        head_x,
    input  logic [8:0]        head_y,
    input  logic [ADDR_W:0]   snake_len,
    output logic [ADDR_W-1:0] body_addr,
    input  logic [9:0]        body_x,
    input  logic [8:0]        body_y,
    input  logic [9:0]        rand_x,
    input  logic [8:0]        rand_y,
    output logic [9:0]        food_x,
    output logic [8:0]        food_y,
    output logic              food_valid,
    output logic              eaten,
    output logic [15:0]       score,
    output logic              gen_fail
);
    localparam int               TRY_W   = $clog2(MAX_TRIES + 1);
    localparam logic [ADDR_W:0]  LEN_MAX = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);
    localparam logic [9:0]       XLO     = 10'(X_MIN);
    localparam logic [9:0]       XHI     = 10'(X_MAX);
    localparam logic [8:0]       YLO     = 9'(Y_MIN);
    localparam logic [8:0]       YHI     = 9'(Y_MAX);

    typedef enum logic [1:0] {SPAWN, CHECK, PLACED} state_t;

    state_t            state_q, state_d;
    logic [9:0]        cand_x_q, cand_x_d;
    logic [8:0]        cand_y_q, cand_y_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [9:0]        food_x_q, food_x_d;
    logic [8:0]        food_y_q, food_y_d;
    logic              food_valid_q, food_valid_d;
    logic [15:0]       score_q, score_d;
    logic              gen_fail_q, gen_fail_d;
    logic              reject, done;

    function automatic logic in_field(input logic [9:0] x, input logic [8:0] y);
        return (x >= XLO) && (x <= XHI) && (y >= YLO) && (y <= YHI);
    endfunction

    function automatic logic [15:0] score_sat_inc(input logic [15:0] s);
        return (s == 16'hFFFF) ? s : s + 16'd1;
    endfunction

    function automatic logic [TRY_W-1:0] try_inc(input logic [TRY_W-1:0] t);
        return (t == TRY_MAX) ? t : t + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        len_d        = len_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        tries_d      = tries_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        score_d      = score_q;
        gen_fail_d   = gen_fail_q;
        eaten        = 1'b0;
        reject       = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            SPAWN: begin
                cand_x_d = rand_x;
                cand_y_d = rand_y;
                len_d    = (snake_len > LEN_MAX) ? LEN_MAX : snake_len;
                idx_d    = '0;
                addr_d   = '0;
                state_d  = CHECK;
            end
            CHECK: begin
                addr_d = addr_q + 1'b1;
                idx_d  = idx_q + 1'b1;
                // idx 0 is the range check; idx i>0 sees RAM data for entry i-1
                if (idx_q == '0) begin
                    reject = !in_field(cand_x_q, cand_y_q);
                    done   = (len_q == '0);
                end else begin
                    reject = (body_x == cand_x_q) && (body_y == cand_y_q);
                    done   = (idx_q == len_q);
                end
                if (reject) begin
                    tries_d = try_inc(tries_q);
                    if (tries_d == TRY_MAX) gen_fail_d = 1'b1;
                    state_d = SPAWN;
                end else if (done) begin
                    food_x_d     = cand_x_q;
                    food_y_d     = cand_y_q;
                    food_valid_d = 1'b1;
                    gen_fail_d   = 1'b0;
                    tries_d      = '0;
                    state_d      = PLACED;
                end
            end
            PLACED: begin
                if (move_tick && (head_x == food_x_q) && (head_y == food_y_q)) begin
                    eaten        = 1'b1;
                    score_d      = score_sat_inc(score_q);
                    food_valid_d = 1'b0;
                    state_d      = SPAWN;
                end
            end
            default: state_d = SPAWN;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= SPAWN;
            idx_q        <= '0;
            addr_q       <= '0;
            tries_q      <= '0;
            food_x_q     <= 10'd320;
            food_y_q     <= 9'd240;
            food_valid_q <= 1'b0;
            score_q      <= SCORE_INIT;
            gen_fail_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            tries_q      <= tries_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            score_q      <= score_d;
            gen_fail_q   <= gen_fail_d;
        end
    end

    // Candidate and scan length are only consumed after SPAWN reloads them.
    always_ff @(posedge CLOCK_50) begin
        cand_x_q <= cand_x_d;
        cand_y_q <= cand_y_d;
        len_q    <= len_d;
    end

    assign body_addr  = addr_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign score      = score_q;
    assign gen_fail   = gen_fail_q;

endmodule
